// File: rtl/bkm_pkg.sv
// Shared definitions for the BKM iteration controller:
// digit codes, mode constants and controller FSM encoding.
package bkm_pkg;

    localparam logic [1:0] BKM_D_ZERO = 2'b00;
    localparam logic [1:0] BKM_D_POS  = 2'b01;
    localparam logic [1:0] BKM_D_NEG  = 2'b11;

    localparam logic BKM_MODE_E = 1'b0;
    localparam logic BKM_MODE_L = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } bkm_state_e;

endpackage

// File: rtl/bkm_control_iter_digit_sel.sv
// BKM digit selector: maps the signed top nibble of a residual
// to a digit in {-1, 0, +1}; L-mode inverts the sign.
module bkm_digit_sel
    import bkm_pkg::*;
(
    input  logic       mode,
    input  logic [3:0] res,
    output logic [1:0] digit
);

    logic signed [3:0] t;
    logic              is_l;

    assign t    = $signed(res);
    assign is_l = (mode == BKM_MODE_L);

    always_comb begin
        digit = BKM_D_ZERO;
        unique case (1'b1)
            (t >= 4'sd2):  digit = is_l ? BKM_D_NEG : BKM_D_POS;
            (t <= -4'sd3): digit = is_l ? BKM_D_POS : BKM_D_NEG;
            default:       digit = BKM_D_ZERO;
        endcase
    end

endmodule

// File: rtl/bkm_control_iter.sv
// BKM iteration controller: sequences n_iter residual updates
// through bkm_control_step and reports the final residuals.
module bkm_control_iter
    import bkm_pkg::*;
#(
    parameter int W        = 64,
    parameter int LOG2W    = 6,
    parameter int LOG2N    = 6,
    parameter int STEP_LAT = 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             enable,
    input  logic             start,
    input  logic             mode,
    input  logic [1:0]       format,
    input  logic [LOG2N-1:0] n_iter,
    input  logic [W/4-1:0]   u_0,
    input  logic [W/4-1:0]   v_0,
    input  logic [W/4-1:0]   u_np1,
    input  logic [W/4-1:0]   v_np1,
    output logic [LOG2N-1:0] n,
    output logic             mode_o,
    output logic [1:0]       format_o,
    output logic [1:0]       d_u_n,
    output logic [1:0]       d_v_n,
    output logic [W/4-1:0]   u_n,
    output logic [W/4-1:0]   v_n,
    output logic             busy,
    output logic             done,
    output logic [W/4-1:0]   u_fin,
    output logic [W/4-1:0]   v_fin
);

    localparam int RW  = W / 4;
    localparam int TOP = (1 << LOG2W) / 4 - 1;
    localparam int CW  = $clog2(STEP_LAT + 1);

    bkm_state_e       state, state_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [LOG2N-1:0] n_r, n_nx, n_inc;
    logic [LOG2N-1:0] niter_r;
    logic             mode_r;
    logic [1:0]       fmt_r;
    logic [RW-1:0]    u_r, v_r, u_nx, v_nx;
    logic [RW-1:0]    u_fin_r, v_fin_r;
    logic             load, cap, fin_ld;

    assign n_inc = n_r + LOG2N'(1);

    always_ff @(posedge clk) begin
        if (srst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            n_r     <= '0;
            niter_r <= '0;
            mode_r  <= 1'b0;
            fmt_r   <= '0;
            u_r     <= '0;
            v_r     <= '0;
            u_fin_r <= '0;
            v_fin_r <= '0;
        end else if (enable) begin
            state <= state_nx;
            cnt   <= cnt_nx;
            n_r   <= n_nx;
            u_r   <= u_nx;
            v_r   <= v_nx;
            if (load) begin
                niter_r <= n_iter;
                mode_r  <= mode;
                fmt_r   <= format;
            end
            if (fin_ld) begin
                u_fin_r <= u_nx;
                v_fin_r <= v_nx;
            end
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        load     = 1'b0;
        cap      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) state_nx = ST_LOAD;
            end
            ST_LOAD: begin
                load     = 1'b1;
                state_nx = (n_iter == '0) ? ST_DONE : ST_ISSUE;
            end
            ST_ISSUE: begin
                cnt_nx   = CW'(STEP_LAT - 1);
                state_nx = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt == '0) begin
                    cap      = 1'b1;
                    state_nx = (n_inc == niter_r) ? ST_DONE : ST_ISSUE;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Final residuals are registered on DONE entry so they are valid alongside done.
    always_comb begin
        n_nx   = n_r;
        u_nx   = u_r;
        v_nx   = v_r;
        fin_ld = (state_nx == ST_DONE) && (state != ST_DONE);
        if (load) begin
            n_nx = '0;
            u_nx = u_0;
            v_nx = v_0;
        end else if (cap) begin
            n_nx = n_inc;
            u_nx = u_np1;
            v_nx = v_np1;
        end
    end

    bkm_digit_sel u_sel_u (
        .mode  (mode_r),
        .res   (u_r[TOP -: 4]),
        .digit (d_u_n)
    );

    bkm_digit_sel u_sel_v (
        .mode  (mode_r),
        .res   (v_r[TOP -: 4]),
        .digit (d_v_n)
    );

    assign n        = n_r;
    assign mode_o   = mode_r;
    assign format_o = fmt_r;
    assign u_n      = u_r;
    assign v_n      = v_r;
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);
    assign u_fin    = u_fin_r;
    assign v_fin    = v_fin_r;

endmodule

// File: tb/tb_bkm_control_iter.sv
// Directed bench for bkm_control_iter with a one-cycle step stub
// (u_np1 = u_n + 1, v_np1 = v_n - 1).
module tb_bkm_control_iter;

    logic        clk = 1'b0;
    logic        srst, enable, start, mode;
    logic [1:0]  format;
    logic [5:0]  n_iter;
    logic [15:0] u_0, v_0, u_np1, v_np1;
    logic [5:0]  n;
    logic        mode_o;
    logic [1:0]  format_o, d_u_n, d_v_n;
    logic [15:0] u_n, v_n, u_fin, v_fin;
    logic        busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    bkm_control_iter #(
        .W(64), .LOG2W(6), .LOG2N(6), .STEP_LAT(1)
    ) dut (
        .clk(clk), .srst(srst), .enable(enable), .start(start),
        .mode(mode), .format(format), .n_iter(n_iter),
        .u_0(u_0), .v_0(v_0), .u_np1(u_np1), .v_np1(v_np1),
        .n(n), .mode_o(mode_o), .format_o(format_o),
        .d_u_n(d_u_n), .d_v_n(d_v_n), .u_n(u_n), .v_n(v_n),
        .busy(busy), .done(done), .u_fin(u_fin), .v_fin(v_fin)
    );

    assign u_np1 = u_n + 16'd1;
    assign v_np1 = v_n - 16'd1;

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start pulse sampled at edge 0; returns in cycle 1.
    task automatic kick(input logic m, input logic [5:0] ni,
                        input logic [15:0] u, input logic [15:0] v);
        mode   = m;
        n_iter = ni;
        u_0    = u;
        v_0    = v;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    task automatic digit_case(input string tag, input logic m,
                              input logic [15:0] u, input logic [15:0] v,
                              input logic [1:0] eu, input logic [1:0] ev);
        kick(m, 6'd1, u, v);
        tick();
        check({tag, "_du"}, 32'(d_u_n), 32'(eu));
        check({tag, "_dv"}, 32'(d_v_n), 32'(ev));
        tick();
        tick();
        check({tag, "_done"}, 32'(done), 32'd1);
        tick();
    endtask

    initial begin
        srst   = 1'b1;
        enable = 1'b1;
        start  = 1'b0;
        mode   = 1'b0;
        format = 2'b00;
        n_iter = '0;
        u_0    = '0;
        v_0    = '0;
        tick();
        tick();
        srst = 1'b0;

        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_n", 32'(n), 32'd0);
        check("rst_un", 32'(u_n), 32'd0);
        check("rst_vn", 32'(v_n), 32'd0);
        check("rst_du", 32'(d_u_n), 32'd0);
        check("rst_dv", 32'(d_v_n), 32'd0);
        check("rst_ufin", 32'(u_fin), 32'd0);

        // Three iterations
        format = 2'b10;
        kick(1'b0, 6'd3, 16'h0010, 16'h0020);
        check("t1_busy_c1", 32'(busy), 32'd1);
        check("t1_done_c1", 32'(done), 32'd0);
        tick();
        check("t1_n_c2", 32'(n), 32'd0);
        check("t1_un_c2", 32'(u_n), 32'h0010);
        check("t1_vn_c2", 32'(v_n), 32'h0020);
        check("t1_fmt", 32'(format_o), 32'd2);
        check("t1_mode", 32'(mode_o), 32'd0);
        tick();
        tick();
        check("t1_n_c4", 32'(n), 32'd1);
        check("t1_un_c4", 32'(u_n), 32'h0011);
        tick();
        tick();
        check("t1_n_c6", 32'(n), 32'd2);
        check("t1_vn_c6", 32'(v_n), 32'h001E);
        tick();
        check("t1_done_c7", 32'(done), 32'd0);
        tick();
        check("t1_done_c8", 32'(done), 32'd1);
        check("t1_busy_c8", 32'(busy), 32'd1);
        check("t1_ufin", 32'(u_fin), 32'h0013);
        check("t1_vfin", 32'(v_fin), 32'h001D);
        tick();
        check("t1_done_c9", 32'(done), 32'd0);
        check("t1_busy_c9", 32'(busy), 32'd0);
        check("t1_ufin_hold", 32'(u_fin), 32'h0013);

        // Digit selection
        digit_case("e_3000", 1'b0, 16'h3000, 16'h8000, 2'b01, 2'b11);
        digit_case("e_d000", 1'b0, 16'hD000, 16'h2000, 2'b11, 2'b01);
        digit_case("e_e000", 1'b0, 16'hE000, 16'h1FFF, 2'b00, 2'b00);
        digit_case("l_3000", 1'b1, 16'h3000, 16'h8000, 2'b11, 2'b01);
        digit_case("l_d000", 1'b1, 16'hD000, 16'h7FFF, 2'b01, 2'b11);
        digit_case("l_e000", 1'b1, 16'hE000, 16'h0000, 2'b00, 2'b00);

        // Zero iterations
        kick(1'b0, 6'd0, 16'h1234, 16'h5678);
        check("z_busy_c1", 32'(busy), 32'd1);
        check("z_done_c1", 32'(done), 32'd0);
        tick();
        check("z_done_c2", 32'(done), 32'd1);
        check("z_ufin", 32'(u_fin), 32'h1234);
        check("z_vfin", 32'(v_fin), 32'h5678);
        check("z_n", 32'(n), 32'd0);
        tick();
        check("z_busy_c3", 32'(busy), 32'd0);

        // Four-cycle stall inside WAIT
        kick(1'b0, 6'd2, 16'h0010, 16'h0020);
        tick();
        tick();
        enable = 1'b0;
        tick();
        check("s_un_c4", 32'(u_n), 32'h0010);
        check("s_done_c4", 32'(done), 32'd0);
        tick();
        check("s_un_c5", 32'(u_n), 32'h0010);
        tick();
        check("s_done_c6", 32'(done), 32'd0);
        check("s_n_c6", 32'(n), 32'd0);
        tick();
        enable = 1'b1;
        check("s_un_c7", 32'(u_n), 32'h0010);
        tick();
        check("s_un_c8", 32'(u_n), 32'h0011);
        check("s_n_c8", 32'(n), 32'd1);
        tick();
        check("s_done_c9", 32'(done), 32'd0);
        tick();
        check("s_done_c10", 32'(done), 32'd1);
        check("s_ufin", 32'(u_fin), 32'h0012);
        check("s_vfin", 32'(v_fin), 32'h001E);
        tick();

        // Reset mid-operation
        format = 2'b11;
        kick(1'b1, 6'd5, 16'h0100, 16'h0200);
        tick();
        tick();
        tick();
        check("r_n_c4", 32'(n), 32'd1);
        srst = 1'b1;
        tick();
        srst = 1'b0;
        check("r_busy", 32'(busy), 32'd0);
        check("r_done", 32'(done), 32'd0);
        check("r_un", 32'(u_n), 32'd0);
        check("r_vn", 32'(v_n), 32'd0);
        check("r_n", 32'(n), 32'd0);
        check("r_mode", 32'(mode_o), 32'd0);
        check("r_fmt", 32'(format_o), 32'd0);
        check("r_ufin", 32'(u_fin), 32'd0);
        for (int i = 0; i < 12; i++) begin
            tick();
            check($sformatf("r_idle_done_%0d", i), 32'(done), 32'd0);
            check($sformatf("r_idle_busy_%0d", i), 32'(busy), 32'd0);
        end
        format = 2'b01;
        kick(1'b0, 6'd1, 16'h0040, 16'h0050);
        tick();
        tick();
        tick();
        check("r2_done_c4", 32'(done), 32'd1);
        check("r2_ufin", 32'(u_fin), 32'h0041);
        check("r2_vfin", 32'(v_fin), 32'h004F);
        tick();

        // Start held high: one op per IDLE visit
        mode   = 1'b0;
        n_iter = 6'd1;
        u_0    = 16'h0070;
        v_0    = 16'h0080;
        start  = 1'b1;
        tick();
        for (int c = 1; c <= 10; c++) begin
            check($sformatf("h_done_c%0d", c), 32'(done),
                  32'((c == 4) || (c == 9)));
            check($sformatf("h_busy_c%0d", c), 32'(busy),
                  32'(!((c == 5) || (c == 10))));
            tick();
        end
        start = 1'b0;
        tick();
        tick();
        tick();
        check("h_done_last", 32'(done), 32'd1);
        check("h_ufin", 32'(u_fin), 32'h0071);
        tick();
        check("h_idle", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
